// File: rtl/multicycle_datapath.sv
// Multicycle RV32I-subset datapath: FETCH/DECODE/EXECUTE/MEM/WB sequencer with a sticky TRAP state.
// Build option: define INSTRET_COUNTER_EN to add the 64-bit instret retired-instruction counter port.

module multicycle_datapath #(
   parameter int addr_data_width = 32,
   parameter int pc_step         = 1,
   parameter int reset_pc        = 0
) (
   input  logic                       clk1,
   input  logic                       reset1,
   output logic                       imem_req,
   output logic [addr_data_width-1:0] imem_addr,
   input  logic [31:0]                imem_rdata,
   input  logic                       imem_ack,
   output logic                       dmem_req,
   output logic                       dmem_we,
   output logic [addr_data_width-1:0] dmem_addr,
   output logic [addr_data_width-1:0] dmem_wdata,
   input  logic [addr_data_width-1:0] dmem_rdata,
   input  logic                       dmem_ack,
   output logic [addr_data_width-1:0] PC,
   output logic [addr_data_width-1:0] alu_out,
   output logic [addr_data_width-1:0] wr_back_data,
   output logic                       retire,
   output logic [2:0]                 state_dbg,
   output logic                       trap
`ifdef INSTRET_COUNTER_EN
   ,
   output logic [63:0]                instret
`endif
);

   localparam int W   = addr_data_width;
   localparam int SHW = $clog2(addr_data_width);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      TRAP    = 3'd5
   } state_t;

   state_t         state, state_nx;
   logic [31:0]    ir;
   logic [W-1:0]   pc_q, rs1_q, rs2_q, imm_q, alu_q, load_q;
   logic [W-1:0]   rf [32];
   logic [W-1:0]   rf_rd1, rf_rd2, imm_i, imm_s, op_b, alu_res, wb_data;
   logic [6:0]     opcode, funct7;
   logic [2:0]     funct3;
   logic [4:0]     rs1_idx, rs2_idx, rd_idx;
   logic [SHW-1:0] shamt;
   logic           is_lw, is_sw, legal, writes_rd;

   assign opcode  = ir[6:0];
   assign rd_idx  = ir[11:7];
   assign funct3  = ir[14:12];
   assign rs1_idx = ir[19:15];
   assign rs2_idx = ir[24:20];
   assign funct7  = ir[31:25];

   assign is_lw     = (opcode == OP_LW) && (funct3 == 3'b010);
   assign is_sw     = (opcode == OP_SW) && (funct3 == 3'b010);
   assign writes_rd = (opcode == OP_R) || (opcode == OP_I) || is_lw;

   assign imm_i  = {{(W-12){ir[31]}}, ir[31:20]};
   assign imm_s  = {{(W-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign rf_rd1 = (rs1_idx == 5'd0) ? '0 : rf[rs1_idx];
   assign rf_rd2 = (rs2_idx == 5'd0) ? '0 : rf[rs2_idx];

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R:  legal = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         OP_I: begin
            case (funct3)
               3'b001:  legal = (funct7 == 7'b0000000);
               3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               default: legal = 1'b1;
            endcase
         end
         OP_LW:   legal = (funct3 == 3'b010);
         OP_SW:   legal = (funct3 == 3'b010);
         default: legal = 1'b0;
      endcase
   end

   // ir[30] selects SUB/SRA for R-type; for I-type only SRAI uses it (there is no SUBI)
   assign op_b  = (opcode == OP_R) ? rs2_q : imm_q;
   assign shamt = op_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      if ((opcode == OP_LW) || (opcode == OP_SW)) begin
         alu_res = rs1_q + imm_q;
      end else begin
         case (funct3)
            3'b000: alu_res = ((opcode == OP_R) && ir[30]) ? (rs1_q - op_b) : (rs1_q + op_b);
            3'b001: alu_res = rs1_q << shamt;
            3'b010: alu_res = {{(W-1){1'b0}}, ($signed(rs1_q) < $signed(op_b))};
            3'b011: alu_res = {{(W-1){1'b0}}, (rs1_q < op_b)};
            3'b100: alu_res = rs1_q ^ op_b;
            3'b101: alu_res = ir[30] ? $unsigned($signed(rs1_q) >>> shamt) : (rs1_q >> shamt);
            3'b110: alu_res = rs1_q | op_b;
            3'b111: alu_res = rs1_q & op_b;
         endcase
      end
   end

   assign wb_data = is_lw ? load_q : alu_q;

   // Handshake: a req stays high with stable address/data until ack is sampled high on a
   // rising clk1 edge; that edge completes the transfer. An ack while req is low is ignored.
   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      trap     = 1'b0;
      case (state)
         FETCH: begin
            imem_req = reset1;
            if (imem_ack) state_nx = DECODE;
         end
         DECODE:  state_nx = legal ? EXECUTE : TRAP;
         EXECUTE: state_nx = (is_lw || is_sw) ? MEM : WB;
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (dmem_ack) state_nx = WB;
         end
         WB: begin
            retire   = 1'b1;
            state_nx = FETCH;
         end
         TRAP:    trap = 1'b1;
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge clk1 or negedge reset1) begin
      if (!reset1) begin
         state  <= FETCH;
         pc_q   <= W'(reset_pc);
         ir     <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         imm_q  <= '0;
         alu_q  <= '0;
         load_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            FETCH:   if (imem_ack) ir <= imem_rdata;
            DECODE: begin
               rs1_q <= rf_rd1;
               rs2_q <= rf_rd2;
               imm_q <= (opcode == OP_SW) ? imm_s : imm_i;
            end
            EXECUTE: alu_q <= alu_res;
            MEM:     if (dmem_ack && is_lw) load_q <= dmem_rdata;
            WB:      pc_q <= pc_q + W'(pc_step);
            default: ;
         endcase
      end
   end

   // x0 is never written, so its entry stays at the reset value of zero
   always_ff @(posedge clk1 or negedge reset1) begin
      if (!reset1) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if ((state == WB) && writes_rd && (rd_idx != 5'd0)) begin
         rf[rd_idx] <= wb_data;
      end
   end

`ifdef INSTRET_COUNTER_EN
   always_ff @(posedge clk1 or negedge reset1) begin
      if (!reset1) instret <= '0;
      else if (retire) instret <= instret + 64'd1;
   end
`endif

   assign imem_addr    = pc_q;
   assign PC           = pc_q;
   assign alu_out      = alu_q;
   assign wr_back_data = wb_data;
   assign dmem_addr    = alu_q;
   assign dmem_wdata   = rs2_q;
   assign state_dbg    = state;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed program, randomized instruction stream
// against an ISA-level reference model, illegal-instruction traps and reset during memory access.

module tb_multicycle_datapath;

   logic        clk1 = 1'b0;
   logic        reset1 = 1'b0;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [31:0] PC, alu_out, wr_back_data;
   logic        retire, trap;
   logic [2:0]  state_dbg;
`ifdef INSTRET_COUNTER_EN
   logic [63:0] instret;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] ref_regs [32];
   logic [31:0] ref_pc;
   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] exp_q [$];

   // clock / reset block
   always #5 clk1 = ~clk1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   multicycle_datapath dut (
      .clk1(clk1), .reset1(reset1),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .PC(PC), .alu_out(alu_out), .wr_back_data(wr_back_data), .retire(retire),
      .state_dbg(state_dbg), .trap(trap)
`ifdef INSTRET_COUNTER_EN
      , .instret(instret)
`endif
   );

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   // ISA-level arithmetic for the supported operations
   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt, input logic [31:0] a,
                                           input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] gen_instr();
      int          kind;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      kind = $urandom_range(0, 9);
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      imm  = 12'($urandom);
      if (kind <= 3) begin
         return enc_r(((f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00,
                      rs2, rs1, f3, rd);
      end else if (kind <= 6) begin
         if (f3 == 3'd1) imm[11:5] = 7'h00;
         if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         return enc_i(imm, rs1, f3, rd, 7'h13);
      end else if (kind == 8) begin
         return enc_s(12'($urandom_range(0, 7) * 4), rs2, 5'd0);
      end
      return enc_i(12'($urandom_range(0, 7) * 4), 5'd0, 3'b010, rd, 7'h03);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
      ref_pc = 32'd0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk1);
      reset1 = 1'b0;
      repeat (2) @(negedge clk1);
      reset1 = 1'b1;
      #1;
      model_reset();
   endtask

   // driver + scoreboard for one legal instruction; starts at the negedge of its first FETCH cycle
   task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly,
                            output logic [31:0] obs_wb, output int obs_lat);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] a, b, res, addr, ld_val, exp_wb, exp_w;
      bit          is_ld, is_st, alt, done;
      int          cyc, fw, dw, dcyc, exp_lat;
      op    = ins[6:0];
      f3    = ins[14:12];
      rd    = ins[11:7];
      rs1   = ins[19:15];
      rs2   = ins[24:20];
      a     = ref_regs[rs1];
      is_ld = (op == 7'h03);
      is_st = (op == 7'h23);
      if (is_st) addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
      else       addr = a + {{20{ins[31]}}, ins[31:20]};
      b   = (op == 7'h33) ? ref_regs[rs2] : {{20{ins[31]}}, ins[31:20]};
      alt = ((op == 7'h33) && ins[30]) || ((op == 7'h13) && (f3 == 3'd5) && ins[30]);
      res = (is_ld || is_st) ? addr : ref_alu(f3, alt, a, b);
      ld_val  = mem_model.exists(addr) ? mem_model[addr] : $urandom();
      exp_wb  = is_ld ? ld_val : res;
      if (!is_st) exp_q.push_back(exp_wb);
      exp_lat = 4 + idly + ((is_ld || is_st) ? ddly + 1 : 0);
      imem_rdata = ins;
      cyc = 0; fw = 0; dw = 0; dcyc = 0; done = 1'b0;
      obs_wb = 32'd0; obs_lat = 0;
      while (!done && cyc < 64) begin
         cyc++;
         if (imem_req) begin
            if (fw == 0) begin
               n_checks++;
               if (imem_addr !== ref_pc) begin
                  n_errors++;
                  $display("FAIL fetch_addr ins=%h: got %h expected %h", ins, imem_addr, ref_pc);
               end
            end
            imem_ack = (fw == idly);
            fw++;
         end else begin
            imem_ack = 1'($urandom_range(0, 1));
         end
         if (dmem_req) begin
            n_checks++;
            if (dmem_addr !== addr || dmem_we !== is_st || (is_st && dmem_wdata !== ref_regs[rs2])) begin
               n_errors++;
               $display("FAIL dmem_access ins=%h: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                        ins, dmem_addr, dmem_we, dmem_wdata, addr, is_st, ref_regs[rs2]);
            end
            dmem_rdata = ld_val;
            dmem_ack   = (dw == ddly);
            dw++;
            dcyc++;
         end else begin
            n_checks++;
            if (dmem_we !== 1'b0) begin
               n_errors++;
               $display("FAIL dmem_we_idle ins=%h: got %b expected 0", ins, dmem_we);
            end
            dmem_rdata = $urandom();
            dmem_ack   = 1'($urandom_range(0, 1));
         end
         if (retire) begin
            done    = 1'b1;
            obs_wb  = wr_back_data;
            obs_lat = cyc;
            n_checks++;
            if (cyc != exp_lat) begin
               n_errors++;
               $display("FAIL latency ins=%h: got %0d expected %0d", ins, cyc, exp_lat);
            end
            n_checks++;
            if (alu_out !== res) begin
               n_errors++;
               $display("FAIL alu_out ins=%h: got %h expected %h", ins, alu_out, res);
            end
            if (!is_st) begin
               exp_w = exp_q.pop_front();
               n_checks++;
               if (wr_back_data !== exp_w) begin
                  n_errors++;
                  $display("FAIL wr_back_data ins=%h: got %h expected %h", ins, wr_back_data, exp_w);
               end
            end
         end
         @(negedge clk1);
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL retire_timeout ins=%h: no retire within %0d cycles", ins, cyc);
         exp_q.delete();
         return;
      end
      n_checks++;
      if (dcyc != ((is_ld || is_st) ? ddly + 1 : 0)) begin
         n_errors++;
         $display("FAIL dmem_hold ins=%h: got %0d cycles expected %0d", ins, dcyc,
                  (is_ld || is_st) ? ddly + 1 : 0);
      end
      if (is_st) mem_model[addr] = ref_regs[rs2];
      else if (rd != 5'd0) ref_regs[rd] = exp_wb;
      ref_pc = ref_pc + 32'd1;
      n_checks++;
      if (PC !== ref_pc) begin
         n_errors++;
         $display("FAIL pc_after ins=%h: got %h expected %h", ins, PC, ref_pc);
      end
   endtask

   task automatic test_reset();
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk1);
      #2 reset1 = 1'b0;
      #1;
      n_checks++;
      if ({imem_req, dmem_req, dmem_we, retire, trap} !== 5'b00000) begin
         n_errors++;
         $display("FAIL reset_ctrl: got req/dreq/we/ret/trap=%b expected 00000",
                  {imem_req, dmem_req, dmem_we, retire, trap});
      end
      n_checks++;
      if (PC !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_pc: got %h expected 0", PC);
      end
      n_checks++;
      if (alu_out !== 32'd0 || wr_back_data !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_alu_wb: got alu=%h wb=%h expected 0 0", alu_out, wr_back_data);
      end
      n_checks++;
      if (dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_dmem: got addr=%h wdata=%h expected 0 0", dmem_addr, dmem_wdata);
      end
      imem_ack = 1'b1;
      repeat (2) @(negedge clk1);
      n_checks++;
      if (imem_req !== 1'b0 || retire !== 1'b0 || PC !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_held: got req=%b retire=%b pc=%h expected 0 0 0", imem_req, retire, PC);
      end
      imem_ack = 1'b0;
      reset1 = 1'b1;
      #1;
      model_reset();
      // registers must read zero again after reset
      begin
         logic [31:0] wb;
         int          lat;
         run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7), 0, 0, wb, lat);
         n_checks++;
         if (wb !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_regs_cleared: got %h expected 0", wb);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] wb;
      int          lat;
      run_instr(32'h00500093, 0, 0, wb, lat);
      n_checks++;
      if (wb !== 32'd5 || lat != 4 || PC !== 32'd1) begin
         n_errors++;
         $display("FAIL addi: got wb=%h lat=%0d pc=%h expected 5 4 1", wb, lat, PC);
      end
      run_instr(32'h00108133, 0, 0, wb, lat);
      n_checks++;
      if (wb !== 32'd10 || alu_out !== 32'd10 || PC !== 32'd2) begin
         n_errors++;
         $display("FAIL add: got wb=%h alu=%h pc=%h expected a a 2", wb, alu_out, PC);
      end
      run_instr(32'h00202423, 0, 3, wb, lat);
      n_checks++;
      if (lat != 8 || mem_model[32'd8] !== 32'd10) begin
         n_errors++;
         $display("FAIL sw: got lat=%0d stored=%h expected 8 a", lat, mem_model[32'd8]);
      end
      mem_model[32'd8] = 32'hDEADBEEF;
      run_instr(32'h00802183, 1, 1, wb, lat);
      n_checks++;
      if (wb !== 32'hDEADBEEF || lat != 7) begin
         n_errors++;
         $display("FAIL lw: got wb=%h lat=%0d expected deadbeef 7", wb, lat);
      end
      run_instr(enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4), 0, 0, wb, lat);
      n_checks++;
      if (wb !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL add_after_lw: got %h expected deadbeef", wb);
      end
      run_instr(32'h00700013, 0, 0, wb, lat);
      run_instr(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6), 0, 0, wb, lat);
      n_checks++;
      if (wb !== 32'd0) begin
         n_errors++;
         $display("FAIL x0_write: got %h expected 0", wb);
      end
   endtask

   task automatic test_random();
      logic [31:0] wb;
      int          lat;
      for (int i = 0; i < 120; i++) begin
         run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 3), wb, lat);
      end
   endtask

   task automatic test_trap();
      logic [31:0] bad [5];
      logic [31:0] wb;
      int          lat, cyc;
      bad[0] = 32'h0000007F;
      bad[1] = enc_r(7'h20, 5'd1, 5'd1, 3'd1, 5'd2);
      bad[2] = enc_i(12'h000, 5'd0, 3'd0, 5'd3, 7'h03);
      bad[3] = enc_i(12'h041, 5'd1, 3'd1, 5'd1, 7'h13);
      bad[4] = {7'h00, 5'd2, 5'd0, 3'b000, 5'd8, 7'h23};
      for (int k = 0; k < 5; k++) begin
         run_instr(enc_i(12'(k + 3), 5'd0, 3'd0, 5'd1, 7'h13), 0, 0, wb, lat);
         imem_rdata = bad[k];
         cyc = 0;
         while (trap !== 1'b1 && cyc < 10) begin
            cyc++;
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            @(negedge clk1);
         end
         n_checks++;
         if (cyc != 2) begin
            n_errors++;
            $display("FAIL trap_entry ins=%h: got %0d cycles expected 2", bad[k], cyc);
         end
         for (int c = 0; c < 24; c++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            dmem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = 32'h00100093;
            n_checks++;
            if ({trap, imem_req, dmem_req, dmem_we, retire} !== 5'b10000 || PC !== ref_pc) begin
               n_errors++;
               $display("FAIL trap_hold ins=%h: got trap/req/dreq/we/ret=%b pc=%h expected 10000 pc=%h",
                        bad[k], {trap, imem_req, dmem_req, dmem_we, retire}, PC, ref_pc);
            end
            @(negedge clk1);
         end
         #2 reset1 = 1'b0;
         #1;
         n_checks++;
         if (trap !== 1'b0 || PC !== 32'd0) begin
            n_errors++;
            $display("FAIL trap_reset: got trap=%b pc=%h expected 0 0", trap, PC);
         end
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         @(negedge clk1);
         reset1 = 1'b1;
         #1;
         model_reset();
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [31:0] wb;
      int          lat, cyc, dcount;
      run_instr(enc_i(12'd77, 5'd0, 3'd0, 5'd2, 7'h13), 0, 0, wb, lat);
      imem_rdata = enc_s(12'd16, 5'd2, 5'd0);
      cyc = 0;
      dcount = 0;
      while (dcount < 2 && cyc < 20) begin
         cyc++;
         if (dmem_req) dcount++;
         if (dcount < 2) begin
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            @(negedge clk1);
         end
      end
      n_checks++;
      if (dcount < 2) begin
         n_errors++;
         $display("FAIL mid_mem_reach: got %0d mem cycles expected 2", dcount);
      end
      #2 reset1 = 1'b0;
      #1;
      n_checks++;
      if ({dmem_req, dmem_we, imem_req, retire} !== 4'b0000) begin
         n_errors++;
         $display("FAIL mid_mem_drop: got dreq/we/req/ret=%b expected 0000",
                  {dmem_req, dmem_we, imem_req, retire});
      end
      dmem_ack = 1'b1;
      @(negedge clk1);
      n_checks++;
      if (retire !== 1'b0 || dmem_req !== 1'b0 || PC !== 32'd0) begin
         n_errors++;
         $display("FAIL mid_mem_held: got retire=%b dreq=%b pc=%h expected 0 0 0", retire, dmem_req, PC);
      end
      dmem_ack = 1'b0;
      reset1 = 1'b1;
      #1;
      model_reset();
      run_instr(enc_r(7'h00, 5'd0, 5'd2, 3'd0, 5'd5), 0, 0, wb, lat);
      n_checks++;
      if (wb !== 32'd0 || PC !== 32'd1) begin
         n_errors++;
         $display("FAIL mid_mem_resume: got wb=%h pc=%h expected 0 1", wb, PC);
      end
   endtask

   initial begin
      imem_rdata = 32'd0;
      imem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      dmem_ack   = 1'b0;
      model_reset();
      do_reset();
      test_directed();
      test_reset();
      test_random();
      test_trap();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
